// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencer: FSM state encoding,
// delay field width and the prescaler width helper.
package timer_seq_pkg;

  localparam int DELAY_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S1,
    ST_S11,
    ST_S110,
    ST_SH0,
    ST_SH1,
    ST_SH2,
    ST_SH3,
    ST_COUNT,
    ST_DONE
  } state_e;

  // Bits needed to hold 0..n-1 (n >= 2).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Prescaler counting 0..CYCLES-1 while enabled; o_tick marks the last cycle
// of each unit. Synchronous clear restarts the unit from zero.
module unit_tick_gen
  import timer_seq_pkg::*;
#(
  parameter int CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Serial 1101 detector, 4-bit delay capture and (delay+1)*CYCLES_PER_UNIT
// timer with done/ack handshake. Optional cancel via TIMER_SEQ_ABORT_EN.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int CYCLES_PER_UNIT = 1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic               i_ack,
`ifdef TIMER_SEQ_ABORT_EN
  input  logic               i_abort,
`endif
  output logic               o_counting,
  output logic               o_done,
  output logic [DELAY_W-1:0] o_count
);

  state_e             r_state;
  // Only d3..d1 need storing; d0 goes straight into the count on the last edge.
  logic [DELAY_W-2:0] r_delay;
  logic [DELAY_W-1:0] r_count;
  logic               r_counting;
  logic               r_done;
  logic               w_tick;
  logic               w_abort;

`ifdef TIMER_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  unit_tick_gen #(
    .CYCLES (CYCLES_PER_UNIT)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (r_state == ST_COUNT),
    .i_clr   (r_state == ST_SH3),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_delay    <= '0;
      r_count    <= '0;
      r_counting <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= i_data ? ST_S1 : ST_IDLE;
        ST_S1:   r_state <= i_data ? ST_S11 : ST_IDLE;
        ST_S11:  r_state <= i_data ? ST_S11 : ST_S110;
        ST_S110: r_state <= i_data ? ST_SH0 : ST_IDLE;
        ST_SH0, ST_SH1, ST_SH2: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_delay <= {r_delay[DELAY_W-3:0], i_data};
            r_state <= (r_state == ST_SH0) ? ST_SH1 :
                       (r_state == ST_SH1) ? ST_SH2 : ST_SH3;
          end
        end
        ST_SH3: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_count    <= {r_delay, i_data};
            r_counting <= 1'b1;
            r_state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (w_abort) begin
            r_count    <= '0;
            r_counting <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_tick) begin
            if (r_count != '0) begin
              r_count <= r_count - DELAY_W'(1);
            end else begin
              r_counting <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_counting = r_counting;
  assign o_done     = r_done;
  assign o_count    = r_count;

endmodule
